// File: rtl/dat_mover.sv
`default_nettype none
// ============================================================================
//  Module   : dat_mover
//  Purpose  : Block-move engine acting as initiator on the single-port data
//             memory. On a start command it copies len bytes from src to dst,
//             one byte per READ/WRITE pair, ascending, with addresses
//             wrapping modulo 2^AW.
//             Optional fill mode writes a constant byte instead of copying.
//             It is compiled in only when DAT_MOVER_FILL_EN is defined.
//  Ports    : clk, rst_n            - clock, async active-low reset
//             start                 - command strobe (IDLE/DONE only)
//             src, dst, len         - command, captured on accept
//             fill, fill_val        - fill-mode command fields
//             busy, done            - transfer active / 1-cycle completion
//             mem_addr, mem_immed   - memory base address and offset
//             mem_wr_en, mem_dat_in - memory write strobe and data
//             mem_dat_out           - combinational memory read data
//  Revision : 1.0 - initial release
// ============================================================================
module dat_mover #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [AW-1:0] len,
  input  logic          fill,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] mem_addr,
  output logic [AW-1:0] mem_immed,
  output logic          mem_wr_en,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q;
  logic [AW-1:0] src_q, dst_q, len_q, idx_q, idx_d;
  logic          busy_q, done_q, wr_en_q;
  logic [AW-1:0] addr_q, immed_q;
  // Doubles as the byte buffer: loaded from mem_dat_out in READ.
  logic [DW-1:0] dat_q;

  logic          accept;
  logic          last;
  logic          fill_start;
  logic          fill_mode;
  logic [DW-1:0] fill_byte_start;
  logic [DW-1:0] fill_byte;

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign idx_d  = idx_q + AW'(1);
  assign last   = (idx_d == len_q);

`ifdef DAT_MOVER_FILL_EN
  logic          fill_q;
  logic [DW-1:0] fill_val_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q     <= 1'b0;
      fill_val_q <= '0;
    end else if (accept) begin
      fill_q     <= fill;
      fill_val_q <= fill_val;
    end
  end

  // The first write of a fill happens straight after accept, so it must
  // use the live inputs rather than the just-captured copies.
  assign fill_start      = fill;
  assign fill_byte_start = fill_val;
  assign fill_mode       = fill_q;
  assign fill_byte       = fill_val_q;
`else
  logic unused_fill;
  assign unused_fill     = ^{fill, fill_val};
  assign fill_start      = 1'b0;
  assign fill_byte_start = '0;
  assign fill_mode       = 1'b0;
  assign fill_byte       = '0;
`endif

  // Single FSM register block; outputs are registered alongside the state
  // so they always reflect the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      immed_q <= '0;
      dat_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          wr_en_q <= 1'b0;
          addr_q  <= '0;
          immed_q <= '0;
          dat_q   <= '0;
          if (start) begin
            src_q <= src;
            dst_q <= dst;
            len_q <= len;
            idx_q <= '0;
            if (len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else if (fill_start) begin
              state_q <= S_WRITE;
              busy_q  <= 1'b1;
              wr_en_q <= 1'b1;
              addr_q  <= dst;
              dat_q   <= fill_byte_start;
            end else begin
              state_q <= S_READ;
              busy_q  <= 1'b1;
              addr_q  <= src;
            end
          end
        end

        S_READ: begin
          state_q <= S_WRITE;
          wr_en_q <= 1'b1;
          addr_q  <= dst_q;
          immed_q <= idx_q;
          dat_q   <= mem_dat_out;
        end

        S_WRITE: begin
          idx_q <= idx_d;
          if (last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            wr_en_q <= 1'b0;
            addr_q  <= '0;
            immed_q <= '0;
            dat_q   <= '0;
          end else if (fill_mode) begin
            immed_q <= idx_d;
            dat_q   <= fill_byte;
          end else begin
            state_q <= S_READ;
            wr_en_q <= 1'b0;
            addr_q  <= src_q;
            immed_q <= idx_d;
            dat_q   <= '0;
          end
        end

        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          wr_en_q <= 1'b0;
          addr_q  <= '0;
          immed_q <= '0;
          dat_q   <= '0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign mem_addr   = addr_q;
  assign mem_immed  = immed_q;
  assign mem_wr_en  = wr_en_q;
  assign mem_dat_in = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_dat_mover.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dat_mover
//  Purpose  : Self-checking bench for dat_mover. A 256-byte memory model is
//             attached to the DUT port; expected reads, writes and done
//             pulses are queued when commands are issued and checked by an
//             independent monitor.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dat_mover;

  localparam int DW = 8;
  localparam int AW = 8;
`ifdef DAT_MOVER_FILL_EN
  localparam bit FILL_EN = 1'b1;
`else
  localparam bit FILL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       fill = 1'b0;
  logic [7:0] src = '0, dst = '0, len = '0, fill_val = '0;
  logic       busy, done, mem_wr_en;
  logic [7:0] mem_addr, mem_immed, mem_dat_in, mem_dat_out;

  logic [7:0] mem   [256];
  logic [7:0] model [256];
  logic       tb_we = 1'b0;
  logic [7:0] tb_a = '0, tb_d = '0;
  logic [7:0] eff;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int busy_cnt = 0;

  typedef struct packed { logic [7:0] base; logic [7:0] off; logic [7:0] data; } acc_t;
  typedef struct packed { int cyc; int busy; } done_t;
  acc_t  rd_q[$];
  acc_t  wr_q[$];
  done_t dn_q[$];
  acc_t  mon_a;
  done_t mon_d;

  always #5 clk = ~clk;

  dat_mover #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .fill       (fill),
    .fill_val   (fill_val),
    .busy       (busy),
    .done       (done),
    .mem_addr   (mem_addr),
    .mem_immed  (mem_immed),
    .mem_wr_en  (mem_wr_en),
    .mem_dat_in (mem_dat_in),
    .mem_dat_out(mem_dat_out)
  );

  // Memory: combinational read, synchronous write; the bench port is only
  // used while the DUT is idle.
  assign eff         = mem_addr + mem_immed;
  assign mem_dat_out = mem[eff];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_wr_en) mem[eff] <= mem_dat_in;
    else if (tb_we) mem[tb_a] <= tb_d;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Monitor: pops expectations whenever the DUT presents an access or done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (mem_wr_en) begin
        chk("wr_while_busy", busy, 1);
        if (wr_q.size() == 0) fail_now("unexpected_write");
        else begin
          mon_a = wr_q.pop_front();
          chk("wr_base", mem_addr, mon_a.base);
          chk("wr_off", mem_immed, mon_a.off);
          chk("wr_data", mem_dat_in, mon_a.data);
        end
      end else if (busy) begin
        if (rd_q.size() == 0) fail_now("unexpected_read");
        else begin
          mon_a = rd_q.pop_front();
          chk("rd_base", mem_addr, mon_a.base);
          chk("rd_off", mem_immed, mon_a.off);
        end
      end else begin
        chk("idle_outputs", {mem_addr, mem_immed, mem_dat_in}, 0);
      end
      if (done) begin
        if (dn_q.size() == 0) fail_now("unexpected_done");
        else begin
          mon_d = dn_q.pop_front();
          chk("done_cycle", cyc, mon_d.cyc);
          chk("busy_cycles", busy_cnt, mon_d.busy);
        end
        busy_cnt = 0;
      end
    end
  end

  // Reference: a transfer is a sequential byte-by-byte copy (or fill) on the
  // model array, with wrapping 8-bit addresses.
  task automatic model_cmd(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                           input logic f, input logic [7:0] fv, input int e0,
                           input int nb, input bit with_done);
    bit         fm;
    int         li;
    logic [7:0] v;
    acc_t       a;
    done_t      dd;
    fm = f && FILL_EN;
    li = int'(l);
    for (int k = 0; k < nb; k++) begin
      v = fm ? fv : model[8'(s + k)];
      model[8'(d + k)] = v;
      if (!fm) begin
        a.base = s; a.off = 8'(k); a.data = 8'h00;
        rd_q.push_back(a);
      end
      a.base = d; a.off = 8'(k); a.data = v;
      wr_q.push_back(a);
    end
    if (with_done) begin
      dd.cyc  = e0 + ((li == 0) ? 1 : (fm ? li + 1 : 2 * li + 1));
      dd.busy = fm ? li : 2 * li;
      dn_q.push_back(dd);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge (E0).
  task automatic issue(input logic [7:0] s, input logic [7:0] d, input logic [7:0] l,
                       input logic f, input logic [7:0] fv, input bit hold);
    start = 1'b1; src = s; dst = d; len = l; fill = f; fill_val = fv;
    model_cmd(s, d, l, f, fv, cyc, int'(l), 1'b1);
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    tb_we = 1'b1; tb_a = a; tb_d = d;
    model[a] = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((dn_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (dn_q.size() != 0 || wr_q.size() != 0 || rd_q.size() != 0) begin
      fail_now("drain_timeout");
      dn_q.delete(); wr_q.delete(); rd_q.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (!done) fail_now("done_timeout");
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s, d, l, fv;
    logic       f;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", mem_wr_en, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_immed", mem_immed, 0);
    chk("rst_dat_in", mem_dat_in, 0);

    @(negedge clk);
    for (int a = 0; a < 256; a++) poke(8'(a), 8'($urandom));
    rst_n = 1'b1;
    @(negedge clk);

    // Basic copy
    for (int i = 0; i < 4; i++) poke(8'(8'h20 + i), 8'(8'h10 + i));
    issue(8'h20, 8'h80, 8'd4, 1'b0, 8'h00, 1'b0);
    drain();
    for (int i = 0; i < 4; i++) chk("copy_byte", mem[8'(8'h80 + i)], 8'(8'h10 + i));

    // Wrapping source
    poke(8'hFE, 8'hAA); poke(8'hFF, 8'hBB); poke(8'h00, 8'hCC);
    issue(8'hFE, 8'h01, 8'd3, 1'b0, 8'h00, 1'b0);
    drain();
    chk("wrap_b0", mem[1], 8'hAA);
    chk("wrap_b1", mem[2], 8'hBB);
    chk("wrap_b2", mem[3], 8'hCC);

    // len=0 followed by a command accepted in the DONE cycle
    poke(8'h11, 8'h3C);
    issue(8'h10, 8'h50, 8'd0, 1'b0, 8'h00, 1'b1);
    issue(8'h11, 8'h51, 8'd1, 1'b0, 8'h00, 1'b0);
    drain();
    chk("b2b_byte", mem[8'h51], 8'h3C);

    // Fill (copy when fill is compiled out)
    for (int i = 0; i < 5; i++) poke(8'(8'h60 + i), 8'(8'hC0 + i));
    issue(8'h60, 8'h40, 8'd5, 1'b1, 8'h5A, 1'b0);
    drain();
    for (int i = 0; i < 5; i++)
      chk("fill_byte", mem[8'(8'h40 + i)], FILL_EN ? 8'h5A : 8'(8'hC0 + i));

    // Reset in cycle 5 of an 8-byte copy
    for (int i = 0; i < 8; i++) begin
      poke(8'(8'hA0 + i), 8'(8'h71 + i));
      poke(8'(8'hC8 + i), 8'h00);
    end
    start = 1'b1; src = 8'hA0; dst = 8'hC8; len = 8'd8; fill = 1'b0;
    model_cmd(8'hA0, 8'hC8, 8'd8, 1'b0, 8'h00, cyc, 2, 1'b0);
    @(negedge clk);                 // cycle 1
    start = 1'b0;
    repeat (3) @(negedge clk);      // cycle 4
    @(posedge clk);                 // enter cycle 5
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_wr_en", mem_wr_en, 0);
    chk("midrst_addr", {mem_addr, mem_immed, mem_dat_in}, 0);
    @(negedge clk);
    @(negedge clk);
    busy_cnt = 0;
    rst_n = 1'b1;
    chk("midrst_pending_wr", wr_q.size(), 0);
    chk("midrst_pending_rd", rd_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("midrst_b1", mem[8'hC9], 8'h72);
    chk("midrst_b2", mem[8'hCA], 8'h00);

    // start pulsed during READ is ignored
    for (int i = 0; i < 4; i++) poke(8'(8'h30 + i), 8'(8'hE0 + i));
    issue(8'h30, 8'h90, 8'd4, 1'b0, 8'h00, 1'b0);
    start = 1'b1; src = 8'h50; dst = 8'hB0; len = 8'd2;
    @(negedge clk);
    start = 1'b0;
    drain();
    for (int i = 0; i < 4; i++) chk("ign_byte", mem[8'(8'h90 + i)], 8'(8'hE0 + i));

    // Random commands, some back-to-back through the DONE cycle
    for (int it = 0; it < 24; it++) begin
      s = 8'($urandom); d = 8'($urandom); l = 8'($urandom_range(0, 24));
      f = 1'($urandom_range(0, 1)); fv = 8'($urandom);
      issue(s, d, l, f, fv, 1'b0);
      if ($urandom_range(0, 2) == 0) begin
        wait_done();
        s = 8'($urandom); d = 8'($urandom); l = 8'($urandom_range(0, 12));
        f = 1'($urandom_range(0, 1)); fv = 8'($urandom);
        issue(s, d, l, f, fv, 1'b0);
      end
      drain();
    end

    for (int a = 0; a < 256; a++) chk("final_mem", mem[a], model[a]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
